// File: rtl/regfile_write_arbiter.sv
// Two-requester write arbiter in front of a single register-file write port.
// Grants are combinational; the winning write is registered onto wr_* one
// cycle later. A requester holding lock keeps the port for up to MAXBURST
// consecutive grants, after which round-robin priority passes to the other.
//
// Handshake: a write is accepted in any cycle where reqX && gntX. A grant is
// never raised without its request, and at most one grant is high at a time.
// The accepted write appears on wr_enable/wr_addr/wr_data exactly one cycle
// later. Writes to register 0 are consumed but never enabled.
module regfile_write_arbiter #(
    parameter int MAXBURST = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic [4:0]  addr0,
    input  logic [31:0] data0,
    input  logic        lock0,
    input  logic        req1,
    input  logic [4:0]  addr1,
    input  logic [31:0] data1,
    input  logic        lock1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        wr_enable,
    output logic [4:0]  wr_addr,
    output logic [31:0] wr_data,
    output logic [1:0]  owner
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_OWN0 = 2'd1;
    localparam logic [1:0] S_OWN1 = 2'd2;

    // A burst limit of one means a lock can never extend ownership.
    localparam bit         CAN_LOCK = (MAXBURST > 1);
    localparam logic [3:0] MAX_CNT  = 4'(MAXBURST);

    logic [1:0] state, state_nxt;
    logic       prio, prio_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic [3:0] cnt_inc;

    logic        accept;
    logic [4:0]  sel_addr;
    logic [31:0] sel_data;

    // Arbiter state register: ownership, round-robin pointer, burst count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            prio  <= 1'b0;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            prio  <= prio_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic: enter/extend/leave ownership based on lock and count.
    always_comb begin
        state_nxt = state;
        prio_nxt  = prio;
        cnt_nxt   = cnt;
        cnt_inc   = cnt + 4'd1;
        case (state)
            S_IDLE: begin
                if (gnt0) begin
                    prio_nxt = 1'b1;
                    if (lock0 && CAN_LOCK) begin
                        state_nxt = S_OWN0;
                        cnt_nxt   = 4'd1;
                    end
                end else if (gnt1) begin
                    prio_nxt = 1'b0;
                    if (lock1 && CAN_LOCK) begin
                        state_nxt = S_OWN1;
                        cnt_nxt   = 4'd1;
                    end
                end
            end
            S_OWN0: begin
                if (req0 && lock0 && (cnt_inc < MAX_CNT)) begin
                    cnt_nxt = cnt_inc;
                end else begin
                    // Leaving ownership hands priority to the other side.
                    state_nxt = S_IDLE;
                    cnt_nxt   = 4'd0;
                    prio_nxt  = 1'b1;
                end
            end
            S_OWN1: begin
                if (req1 && lock1 && (cnt_inc < MAX_CNT)) begin
                    cnt_nxt = cnt_inc;
                end else begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = 4'd0;
                    prio_nxt  = 1'b0;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

    // Grant outputs: owner-exclusive while locked, round-robin when idle.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst_n) begin
            case (state)
                S_IDLE: begin
                    if (req0 && (!req1 || !prio)) gnt0 = 1'b1;
                    else if (req1)                gnt1 = 1'b1;
                end
                S_OWN0:  gnt0 = req0;
                S_OWN1:  gnt1 = req1;
                default: ;
            endcase
        end
    end

    assign owner    = state;
    assign accept   = gnt0 | gnt1;
    assign sel_addr = gnt1 ? addr1 : addr0;
    assign sel_data = gnt1 ? data1 : data0;

    // Write port register: register 0 writes are swallowed, idle cycles hold addr/data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_enable <= 1'b0;
            wr_addr   <= 5'd0;
            wr_data   <= 32'd0;
        end else begin
            wr_enable <= accept && (sel_addr != 5'd0);
            if (accept && (sel_addr != 5'd0)) begin
                wr_addr <= sel_addr;
                wr_data <= sel_data;
            end
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: a default instance (MAXBURST=4)
// and a MAXBURST=1 instance share the same stimulus.
module tb_regfile_write_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0, req1, lock0, lock1;
    logic [4:0]  addr0, addr1;
    logic [31:0] data0, data1;

    logic        gnt0, gnt1, wr_enable;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [1:0]  owner;

    logic        b_gnt0, b_gnt1, b_wr_enable;
    logic [4:0]  b_wr_addr;
    logic [31:0] b_wr_data;
    logic [1:0]  b_owner;

    int n_checks = 0;
    int n_pass   = 0;

    regfile_write_arbiter #(.MAXBURST(4)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .addr0(addr0), .data0(data0), .lock0(lock0),
        .req1(req1), .addr1(addr1), .data1(data1), .lock1(lock1),
        .gnt0(gnt0), .gnt1(gnt1),
        .wr_enable(wr_enable), .wr_addr(wr_addr), .wr_data(wr_data),
        .owner(owner)
    );

    regfile_write_arbiter #(.MAXBURST(1)) u_dut_b1 (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .addr0(addr0), .data0(data0), .lock0(lock0),
        .req1(req1), .addr1(addr1), .data1(data1), .lock1(lock1),
        .gnt0(b_gnt0), .gnt1(b_gnt1),
        .wr_enable(b_wr_enable), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
        .owner(b_owner)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Driver tasks
    task automatic drive(input logic r0, input logic [4:0] a0, input logic [31:0] d0, input logic l0,
                         input logic r1, input logic [4:0] a1, input logic [31:0] d1, input logic l1);
        req0 = r0; addr0 = a0; data0 = d0; lock0 = l0;
        req1 = r1; addr1 = a1; data1 = d1; lock1 = l1;
    endtask

    task automatic idle_in();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_in();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        idle_in();

        // Reset state, with a request present that must not be granted
        @(negedge clk);
        drive(1'b1, 5'd3, 32'h1, 1'b0, 1'b1, 5'd4, 32'h2, 1'b0);
        #1;
        check("rst_gnt0", {31'd0, gnt0}, 32'd0);
        check("rst_gnt1", {31'd0, gnt1}, 32'd0);
        check("rst_wr_enable", {31'd0, wr_enable}, 32'd0);
        check("rst_wr_addr", {27'd0, wr_addr}, 32'd0);
        check("rst_wr_data", wr_data, 32'd0);
        check("rst_owner", {30'd0, owner}, 32'd0);
        @(negedge clk);
        idle_in();
        rst_n = 1'b1;

        // Single write from requester 0
        drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
        #1;
        check("single_gnt0", {31'd0, gnt0}, 32'd1);
        check("single_gnt1", {31'd0, gnt1}, 32'd0);
        @(negedge clk);
        idle_in();
        #1;
        check("single_wr_enable", {31'd0, wr_enable}, 32'd1);
        check("single_wr_addr", {27'd0, wr_addr}, 32'd5);
        check("single_wr_data", wr_data, 32'hDEADBEEF);
        check("single_owner", {30'd0, owner}, 32'd0);
        @(negedge clk);
        #1;
        check("idle_wr_enable", {31'd0, wr_enable}, 32'd0);
        check("idle_wr_addr_hold", {27'd0, wr_addr}, 32'd5);
        check("idle_wr_data_hold", wr_data, 32'hDEADBEEF);

        // Round-robin alternation, no lock
        do_reset();
        drive(1'b1, 5'd1, 32'h100, 1'b0, 1'b1, 5'd2, 32'h200, 1'b0);
        for (int i = 0; i < 4; i++) begin
            #1;
            check("rr_gnt0", {31'd0, gnt0}, (i % 2 == 0) ? 32'd1 : 32'd0);
            check("rr_gnt1", {31'd0, gnt1}, (i % 2 == 1) ? 32'd1 : 32'd0);
            if (i > 0) begin
                check("rr_wr_enable", {31'd0, wr_enable}, 32'd1);
                check("rr_wr_addr", {27'd0, wr_addr}, ((i - 1) % 2 == 0) ? 32'd1 : 32'd2);
            end
            @(negedge clk);
        end
        idle_in();
        #1;
        check("rr_last_wr_enable", {31'd0, wr_enable}, 32'd1);
        check("rr_last_wr_addr", {27'd0, wr_addr}, 32'd2);
        check("rr_last_wr_data", wr_data, 32'h200);
        @(negedge clk);

        // Locked burst of MAXBURST grants, then the waiting requester
        do_reset();
        drive(1'b1, 5'd3, 32'hA5A50003, 1'b1, 1'b1, 5'd4, 32'hA5A50004, 1'b0);
        for (int i = 0; i < 5; i++) begin
            #1;
            check("burst_gnt0", {31'd0, gnt0}, (i < 4) ? 32'd1 : 32'd0);
            check("burst_gnt1", {31'd0, gnt1}, (i == 4) ? 32'd1 : 32'd0);
            check("burst_owner", {30'd0, owner}, (i >= 1 && i <= 3) ? 32'd1 : 32'd0);
            check("b1_gnt0", {31'd0, b_gnt0}, (i % 2 == 0) ? 32'd1 : 32'd0);
            check("b1_owner", {30'd0, b_owner}, 32'd0);
            @(negedge clk);
        end

        // Address-0 write is granted but never enabled
        drive(1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 5'd0, 32'h12345678, 1'b0);
        #1;
        check("zero_gnt1", {31'd0, gnt1}, 32'd1);
        check("burst_tail_wr_addr", {27'd0, wr_addr}, 32'd4);
        check("burst_tail_wr_data", wr_data, 32'hA5A50004);
        @(negedge clk);
        idle_in();
        #1;
        check("zero_wr_enable", {31'd0, wr_enable}, 32'd0);
        check("zero_wr_addr_hold", {27'd0, wr_addr}, 32'd4);
        check("zero_wr_data_hold", wr_data, 32'hA5A50004);
        @(negedge clk);

        // Owner drops its request: one empty cycle, then the other side
        do_reset();
        drive(1'b1, 5'd9, 32'h99, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
        #1;
        check("drop_first_gnt0", {31'd0, gnt0}, 32'd1);
        @(negedge clk);
        drive(1'b0, 5'd9, 32'h99, 1'b1, 1'b1, 5'd6, 32'h66, 1'b0);
        #1;
        check("drop_gnt0", {31'd0, gnt0}, 32'd0);
        check("drop_gnt1_blocked", {31'd0, gnt1}, 32'd0);
        check("drop_owner", {30'd0, owner}, 32'd1);
        check("drop_wr_addr", {27'd0, wr_addr}, 32'd9);
        @(negedge clk);
        #1;
        check("drop_owner_idle", {30'd0, owner}, 32'd0);
        check("drop_gnt1", {31'd0, gnt1}, 32'd1);
        check("drop_gap_wr_enable", {31'd0, wr_enable}, 32'd0);
        @(negedge clk);
        idle_in();
        #1;
        check("drop_wr_enable", {31'd0, wr_enable}, 32'd1);
        check("drop_wr_data", wr_data, 32'h66);

        // Asynchronous reset kills a pending write to register 7
        @(negedge clk);
        drive(1'b1, 5'd7, 32'h77, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
        #1;
        check("pend_gnt0", {31'd0, gnt0}, 32'd1);
        @(posedge clk);
        #2;
        check("pend_wr_enable", {31'd0, wr_enable}, 32'd1);
        check("pend_wr_addr", {27'd0, wr_addr}, 32'd7);
        rst_n = 1'b0;
        #1;
        check("arst_wr_enable", {31'd0, wr_enable}, 32'd0);
        check("arst_wr_addr", {27'd0, wr_addr}, 32'd0);
        check("arst_wr_data", wr_data, 32'd0);
        check("arst_owner", {30'd0, owner}, 32'd0);
        check("arst_gnt0", {31'd0, gnt0}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 5'd1, 32'h11, 1'b0, 1'b1, 5'd2, 32'h22, 1'b0);
        #1;
        check("post_rst_gnt0", {31'd0, gnt0}, 32'd1);
        check("post_rst_gnt1", {31'd0, gnt1}, 32'd0);
        @(negedge clk);
        idle_in();
        #1;
        check("post_rst_wr_addr", {27'd0, wr_addr}, 32'd1);
        check("post_rst_wr_data", wr_data, 32'h11);
        @(negedge clk);

        // Final report
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001: Parameter MAXBURST, default 4, legal range 1..15: maximum consecutive grants one requester holds while asserting lock.
REQ-002: The block SHALL use one clock; reset SHALL be asynchronous and active-low.
REQ-003: clk  input  1  clock; all state updates on posedge.
REQ-004: rst_n  input  1  asynchronous active-low reset.
REQ-005: req0 / req1  input  1  write request from requester 0 / 1.
REQ-006: addr0 / addr1  input  5  destination register index of requester 0 / 1.
REQ-007: data0 / data1  input  32  write data of requester 0 / 1.
REQ-008: lock0 / lock1  input  1  requester asks to keep the port after this grant.
REQ-009: gnt0 / gnt1  output  1  combinational grant; a write is accepted in any cycle where reqX and gntX are both 1.
REQ-010: wr_enable  output  1  registered write enable to the register file write port.
REQ-011: wr_addr  output  5  registered write register index.
REQ-012: wr_data  output  32  registered write data.
REQ-013: owner  output  2  registered state: 0 IDLE, 1 OWN0, 2 OWN1.

Function
REQ-014: At most one of gnt0/gnt1 SHALL be 1 in any cycle; a gnt SHALL never be asserted without its req.
REQ-015: State machine states: IDLE, OWN0, OWN1; 1-bit round-robin pointer prio; 4-bit burst counter cnt.
REQ-016: IDLE, single requester: grant it.
REQ-017: IDLE, both requesting: grant the requester equal to prio.
REQ-018: IDLE grant to X: prio becomes the other requester. If lockX=1 and MAXBURST>1, next state OWNX with cnt=1. Otherwise stay IDLE.
REQ-019: OWNX: only X may be granted; the other requester SHALL see gnt=0 even when requesting.
REQ-020: OWNX with reqX=1: grant X and increment cnt. Stay in OWNX only if lockX=1 and the incremented cnt<MAXBURST; otherwise go to IDLE.
REQ-021: OWNX with reqX=0: no grant this cycle; next state IDLE; cnt cleared.
REQ-022: Entering IDLE from OWNX: prio SHALL point to the other requester, so a waiting requester is served next cycle.
REQ-023: Latency: a write accepted in cycle N SHALL appear on wr_enable/wr_addr/wr_data in cycle N+1, exactly one cycle.
REQ-024: An accepted write with address 0 SHALL be granted (consumed) but SHALL produce wr_enable=0 in cycle N+1, because register 0 is hardwired zero.
REQ-025: In a cycle after no accepted write, wr_enable SHALL be 0. wr_addr and wr_data SHALL hold their last values.
REQ-026: Back-to-back accepted writes SHALL produce wr_enable=1 on consecutive cycles with no bubble.
REQ-027: Address collision (both requesting the same index) SHALL be ordered purely by arbitration; the later grant overwrites the earlier one in the register file.

Reset
REQ-028: While rst_n=0: owner=IDLE, prio=0, cnt=0, wr_enable=0, wr_addr=0, wr_data=0, gnt0=gnt1=0.
REQ-029: Reset asserted mid-burst or with a write pending on wr_* SHALL clear wr_enable immediately (asynchronously); the pending write SHALL NOT commit.
REQ-030: After rst_n deasserts, the first posedge SHALL behave as IDLE with prio=0.

Verification
REQ-031: Reset, then req0=1 addr0=5 data0=0xDEADBEEF lock0=0 -> gnt0=1 same cycle; next cycle wr_enable=1, wr_addr=5, wr_data=0xDEADBEEF; owner stays 0.
REQ-032: req0=req1=1 for 4 cycles, no lock, addresses 1 and 2 -> grants alternate 0,1,0,1; wr_addr sequence is 1,2,1,2 with wr_enable=1 every cycle.
REQ-033: MAXBURST=4; req0=lock0=1 and req1=1 held -> gnt0 for 4 consecutive cycles (owner=1 for cycles 2-4); gnt1 on cycle 5; owner=0 at cycle 5.
REQ-034: req1=1 addr1=0 data1=0x12345678 -> gnt1=1; next cycle wr_enable=0; wr_addr/wr_data unchanged.
REQ-035: OWN0 with req0 dropped to 0 while req1=1 -> one cycle with no grant and owner returns to 0; next cycle gnt1=1.
REQ-036: rst_n pulsed low one cycle after an accepted write to address 7 -> wr_enable falls during reset, no commit to register 7; all outputs read 0.
